// File: rtl/mips_pkg.sv
// Shared MIPS32 definitions: opcode/funct codes, ALU encodings and the
// packed control bundle that travels from ID into EX.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    alu_src_imm;
    alu_op_t alu_op;
    logic    illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b0};
  // Illegal instructions carry no write/memory/branch side effects at all.
  localparam ctrl_t CTRL_ILLEGAL = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b1};

endpackage

// File: rtl/register_file.sv
// 32-entry register file: two combinational read ports with write-through
// bypass, one write port, synchronous active-low clear, r0 reads as zero.
module register_file #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [RADDR_W-1:0] ra1,
  input  logic [RADDR_W-1:0] ra2,
  output logic [DATA_W-1:0]  rd1,
  output logic [DATA_W-1:0]  rd2,
  input  logic               we,
  input  logic [RADDR_W-1:0] wa,
  input  logic [DATA_W-1:0]  wd
);

  localparam int NREGS = 1 << RADDR_W;

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  // A same-cycle write to the addressed register wins over the array value.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) begin
      rd1 = (we && (wa == ra1)) ? wd : regs[ra1];
    end
    if (ra2 != '0) begin
      rd2 = (we && (wa == ra2)) ? wd : regs[ra2];
    end
  end

endmodule

// File: rtl/instruction_decode.sv
// ID stage: decodes one instruction per cycle, reads operands and registers
// the decode into the ID/EX pipeline register.
module instruction_decode
  import mips_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instr_in,
  input  logic               instr_valid,
  input  logic               stall,
  input  logic               flush,
  input  logic               wb_en,
  input  logic [RADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               id_valid,
  output logic [DATA_W-1:0]  rs_data,
  output logic [DATA_W-1:0]  rt_data,
  output logic [DATA_W-1:0]  imm_ext,
  output logic [RADDR_W-1:0] dest_addr,
  output logic [2:0]         alu_op,
  output logic               alu_src_imm,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               branch,
  output logic               illegal
);

  // Handshake: instr_in is taken on an edge only when instr_valid=1 and
  // neither stall nor flush is high; stall holds ID/EX, flush (which beats
  // stall) inserts a bubble, and instr_valid=0 on a load also inserts one.

  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [RADDR_W-1:0] rs_addr;
  logic [RADDR_W-1:0] rt_addr;
  logic [RADDR_W-1:0] rd_addr;

  assign opcode  = instr_in[31:26];
  assign funct   = instr_in[5:0];
  assign rs_addr = instr_in[21 +: RADDR_W];
  assign rt_addr = instr_in[16 +: RADDR_W];
  assign rd_addr = instr_in[11 +: RADDR_W];

  logic [DATA_W-1:0] rf_rs;
  logic [DATA_W-1:0] rf_rt;

  register_file #(
    .DATA_W (DATA_W),
    .RADDR_W(RADDR_W)
  ) u_register_file (
    .clk  (clk),
    .rst_n(rst_n),
    .ra1  (rs_addr),
    .ra2  (rt_addr),
    .rd1  (rf_rs),
    .rd2  (rf_rt),
    .we   (wb_en),
    .wa   (wb_addr),
    .wd   (wb_data)
  );

  ctrl_t              dec_ctrl;
  logic [RADDR_W-1:0] dec_dest;
  logic [DATA_W-1:0]  dec_imm;

  assign dec_imm = {{(DATA_W-16){instr_in[15]}}, instr_in[15:0]};

  // The all-zero word (sll $0 nop) falls through as a legal no-op.
  always_comb begin
    dec_ctrl = CTRL_NONE;
    dec_dest = '0;
    if (instr_in != 32'h0000_0000) begin
      case (opcode)
        OP_RTYPE: begin
          dec_ctrl.reg_write = 1'b1;
          dec_dest           = rd_addr;
          case (funct)
            FN_ADD:  dec_ctrl.alu_op = ALU_ADD;
            FN_SUB:  dec_ctrl.alu_op = ALU_SUB;
            FN_AND:  dec_ctrl.alu_op = ALU_AND;
            FN_OR:   dec_ctrl.alu_op = ALU_OR;
            FN_SLT:  dec_ctrl.alu_op = ALU_SLT;
            default: begin
              dec_ctrl = CTRL_ILLEGAL;
              dec_dest = '0;
            end
          endcase
        end
        OP_ADDI: begin
          dec_ctrl.reg_write   = 1'b1;
          dec_ctrl.alu_src_imm = 1'b1;
          dec_dest             = rt_addr;
        end
        OP_LW: begin
          dec_ctrl.reg_write   = 1'b1;
          dec_ctrl.mem_read    = 1'b1;
          dec_ctrl.alu_src_imm = 1'b1;
          dec_dest             = rt_addr;
        end
        OP_SW: begin
          dec_ctrl.mem_write   = 1'b1;
          dec_ctrl.alu_src_imm = 1'b1;
        end
        OP_BEQ: begin
          dec_ctrl.branch = 1'b1;
          dec_ctrl.alu_op = ALU_SUB;
        end
        default: dec_ctrl = CTRL_ILLEGAL;
      endcase
    end
  end

  ctrl_t              ctrl_q;
  logic               valid_q;
  logic [DATA_W-1:0]  rs_q;
  logic [DATA_W-1:0]  rt_q;
  logic [DATA_W-1:0]  imm_q;
  logic [RADDR_W-1:0] dest_q;

  // Bubbles clear only valid and control; operand/data fields keep their values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_NONE;
      rs_q    <= '0;
      rt_q    <= '0;
      imm_q   <= '0;
      dest_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_NONE;
    end else if (stall) begin
      valid_q <= valid_q;
    end else if (instr_valid) begin
      valid_q <= 1'b1;
      ctrl_q  <= dec_ctrl;
      rs_q    <= rf_rs;
      rt_q    <= rf_rt;
      imm_q   <= dec_imm;
      dest_q  <= dec_dest;
    end else begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_NONE;
    end
  end

  assign id_valid    = valid_q;
  assign rs_data     = rs_q;
  assign rt_data     = rt_q;
  assign imm_ext     = imm_q;
  assign dest_addr   = dest_q;
  assign alu_op      = ctrl_q.alu_op;
  assign alu_src_imm = ctrl_q.alu_src_imm;
  assign reg_write   = ctrl_q.reg_write;
  assign mem_read    = ctrl_q.mem_read;
  assign mem_write   = ctrl_q.mem_write;
  assign branch      = ctrl_q.branch;
  assign illegal     = ctrl_q.illegal;

endmodule

// File: doc/instruction_decode.md
# instruction_decode

Second pipeline stage of the MIPS32 core, directly downstream of instruction fetch. It accepts one 32-bit instruction per cycle, reads two source operands from an internal 32×32 register file, and sign-extends the immediate. It generates datapath control and registers everything into the ID/EX pipeline register. The register file write port is driven by the writeback stage.

## Interface
- `DATA_W`, 32, datapath and register width
- `RADDR_W`, 5, register address width (32 registers)

- `clk`  in  1  rising-edge clock for all state
- `rst_n`  in  1  synchronous reset, active-low
- `instr_in`  in  32  instruction word from fetch
- `instr_valid`  in  1  `instr_in` holds a real instruction this cycle
- `stall`  in  1  hold ID/EX contents; ignore `instr_in`
- `flush`  in  1  replace next ID/EX contents with a bubble
- `wb_en`  in  1  register file write enable
- `wb_addr`  in  5  write register index
- `wb_data`  in  32  write data
- `id_valid`  out  1  ID/EX holds a real instruction
- `rs_data`, `rt_data`  out  32 each  source operand values
- `imm_ext`  out  32  sign-extended `instr[15:0]`
- `dest_addr`  out  5  destination register: `rd` for R-type, `rt` for addi/lw, 0 otherwise
- `alu_op`  out  3  0=add, 1=sub, 2=and, 3=or, 4=slt
- `alu_src_imm`  out  1  ALU B operand is `imm_ext`
- `reg_write`, `mem_read`, `mem_write`, `branch`  out  1 each  control flags
- `illegal`  out  1  unsupported opcode/funct was decoded

## Operation
- Decoded set:
  - R-type (opcode 0x00) funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - addi 0x08, lw 0x23, sw 0x2B, beq 0x04.
- Controls per instruction:
  - R-type: reg_write=1.
  - addi: reg_write=1, alu_src_imm=1, alu_op=add.
  - lw: reg_write=1, mem_read=1, alu_src_imm=1, alu_op=add.
  - sw: mem_write=1, alu_src_imm=1, alu_op=add.
  - beq: branch=1, alu_op=sub.
- Instruction word 0x00000000 (sll $0 nop) decodes as a bubble: id_valid=1, all controls 0, illegal=0.
- Any other opcode/funct: id_valid=1, illegal=1, all other controls 0. The instruction is never allowed to write state.
- Register file:
  - r0 always reads 0; writes to r0 are discarded.
  - Write occurs on the rising edge when `wb_en`=1, independent of stall/flush.
- Write-through bypass: if `wb_en` and `wb_addr`≠0 and `wb_addr` equals `rs` (or `rt`), the captured operand is `wb_data`, not the stale array value.

## Timing
- Latency is 1 cycle. An instruction presented at edge N appears on the outputs after edge N.
- Per-edge priority: `!rst_n` > `flush` > `stall` > load.
  - reset: all outputs 0, all 32 registers cleared to 0.
  - flush: id_valid=0 and all control flags 0. Data outputs keep their previous values.
  - stall: all outputs hold. The register file still accepts writes, and stalled operand outputs are not refreshed.
  - load with `instr_valid`=1: capture the decode.
  - load with `instr_valid`=0: load a bubble (id_valid=0, controls 0).
- Simultaneous `flush` and `stall`: flush wins.
- Reset asserted mid-stream clears the pipeline register and the register file on that edge. The first instruction after deassertion is decoded normally at the next edge.
- Arithmetic: `imm_ext` = {{16{instr[15]}}, instr[15:0]}. No other arithmetic is done in this stage.

## Structure
- Shared package `mips_pkg` holds:
  - opcode and funct localparams
  - `alu_op` encodings
  - a packed control struct (reg_write, mem_read, mem_write, branch, alu_src_imm, alu_op, illegal), reused by the EX stage.
- Sub-module `register_file`: 2 read ports, 1 write port, synchronous active-low clear, r0 hardwired zero, write-through bypass.
- Top level contains the combinational decoder and the ID/EX register.

## Test plan
- **Reset clear:** reset for 2 cycles, then decode `add $3,$1,$2` (0x00221820) -> id_valid=1, rs_data=0, rt_data=0, dest_addr=3, reg_write=1, alu_op=0.
- **Bypass:** write r1=5 and r2=7 via wb_en. Present `sub $4,$1,$2` (0x00222022) while writing r2=9 in the same cycle -> rs_data=5, rt_data=9, alu_op=1, dest_addr=4.
- **I-type:**
  - `lw $5,-4($1)` (0x8C25FFFC) -> imm_ext=0xFFFFFFFC, mem_read=1, alu_src_imm=1, dest_addr=5.
  - `sw` (0xAC25000C) -> mem_write=1, reg_write=0, imm_ext=0x0000000C.
- **r0 protection:** wb_en with wb_addr=0 and wb_data=0xDEADBEEF, then read r0 -> rs_data=0.
- **Stall/flush:**
  - Stall for 3 cycles while instr_in changes -> outputs unchanged.
  - Assert flush and stall together -> id_valid=0, reg_write=0.
  - Reset asserted during a stall -> all outputs 0 on that edge.
- **Illegal:** opcode 0x3F (0xFC000000) -> id_valid=1, illegal=1, reg_write=mem_write=mem_read=branch=0.
